// File: rtl/final_soc_cmd_out_if.sv
// Avalon-MM write port plus valid/ready output stream for the command-out mailbox.
// The master side is the bus/fabric environment; the slave side is the mailbox.
interface final_soc_cmd_out_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       address;
  logic             write;
  logic [31:0]      writeData;
  logic [31:0]      readData;
  logic [WIDTH-1:0] outData;
  logic             outValid;
  logic             outReady;

  modport master (
    output address, write, writeData, outReady,
    input  readData, outData, outValid
  );

  modport slave (
    input  address, write, writeData, outReady,
    output readData, outData, outValid
  );
endinterface

// File: rtl/final_soc_cmd_out.sv
// Nios II output mailbox: bus writes fill a first-word-fall-through FIFO that drains
// to the recognition fabric, with status, sticky overflow, flush and enable registers.
module final_soc_cmd_out #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                reset_n,
  final_soc_cmd_out_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_enable;
  logic [31:0]      r_readData;

  logic        w_empty;
  logic        w_full;
  logic        w_pushReq;
  logic        w_push;
  logic        w_dropPush;
  logic        w_pop;
  logic        w_flush;
  logic        w_clearOverflow;
  logic        w_enableWrite;
  logic [7:0]  w_count8;
  logic [31:0] w_readMux;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

  // Fullness is judged on the pre-edge count, so a push into a full FIFO is dropped
  // even when a pop frees a slot on the same edge.
  assign w_pushReq       = bus.write && (bus.address == 2'd0);
  assign w_push          = w_pushReq && !w_full;
  assign w_dropPush      = w_pushReq && w_full;
  assign w_flush         = bus.write && (bus.address == 2'd1) && bus.writeData[1];
  assign w_clearOverflow = bus.write && (bus.address == 2'd1) && bus.writeData[0];
  assign w_enableWrite   = bus.write && (bus.address == 2'd2);

  assign bus.outData  = r_mem[r_rdPtr];
  assign bus.outValid = r_enable && !w_empty;
  assign w_pop        = bus.outValid && bus.outReady;

  assign w_count8     = 8'(r_count);
  assign bus.readData = r_readData;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= bus.writeData[WIDTH-1:0];
    end
  end

  always_comb begin
    w_readMux = '0;
    case (bus.address)
      2'd0: w_readMux = w_empty ? 32'd0 : 32'(bus.outData);
      2'd1: w_readMux = {16'b0, w_count8, 5'b0, r_overflow, w_full, w_empty};
      2'd2: w_readMux = {31'b0, r_enable};
      default: w_readMux = '0;
    endcase
  end

  // Flush only resets the pointers; stale storage stays but is masked by count==0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_enable   <= 1'b0;
      r_readData <= '0;
    end else begin
      if (w_flush) begin
        r_rdPtr <= '0;
        r_wrPtr <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_wrPtr <= r_wrPtr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rdPtr <= r_rdPtr + PTR_W'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - CNT_W'(1);
        end
      end

      if (w_dropPush) begin
        r_overflow <= 1'b1;
      end else if (w_clearOverflow) begin
        r_overflow <= 1'b0;
      end

      if (w_enableWrite) begin
        r_enable <= bus.writeData[0];
      end

      r_readData <= w_readMux;
    end
  end
endmodule

// File: tb/tb_final_soc_cmd_out.sv
// Self-checking bench for final_soc_cmd_out: a queue-based mailbox model checked every
// cycle, directed scenarios with literal expectations, then a randomized soak.
module tb_final_soc_cmd_out;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  final_soc_cmd_out_if #(.WIDTH(32)) bus ();

  final_soc_cmd_out #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int assertCount = 0;
  int failCount = 0;

  logic [31:0] mQueue [$];
  bit          mOverflow = 1'b0;
  bit          mEnable = 1'b0;
  logic [31:0] mReadExp = 32'd0;
  bit          checkEn = 1'b0;
  bit          logPops = 1'b0;
  logic [31:0] popLog [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      2'd0: v = (mQueue.size() != 0) ? mQueue[0] : 32'd0;
      2'd1: v = {16'b0, 8'(mQueue.size()), 5'b0, mOverflow, (mQueue.size() == DEPTH), (mQueue.size() == 0)};
      2'd2: v = {31'b0, mEnable};
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // Mailbox model: a queue of pending words plus the two software flags.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mQueue.delete();
      mOverflow = 1'b0;
      mEnable = 1'b0;
      mReadExp = 32'd0;
    end else begin
      bit wasFull;
      bit popNow;
      mReadExp = modelRead(bus.address);
      wasFull = (mQueue.size() == DEPTH);
      popNow = mEnable && (mQueue.size() != 0) && bus.outReady;
      if (bus.write && bus.address == 2'd1 && bus.writeData[1]) mQueue.delete();
      else if (popNow) void'(mQueue.pop_front());
      if (bus.write && bus.address == 2'd0) begin
        if (wasFull) mOverflow = 1'b1;
        else mQueue.push_back(bus.writeData);
      end
      if (bus.write && bus.address == 2'd1 && bus.writeData[0]) mOverflow = 1'b0;
      if (bus.write && bus.address == 2'd2) mEnable = bus.writeData[0];
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("outValid", 32'(bus.outValid), 32'(mEnable && (mQueue.size() != 0)));
      if (mEnable && mQueue.size() != 0) checkOutput("outData", bus.outData, mQueue[0]);
      checkOutput("readData", bus.readData, mReadExp);
      if (logPops && bus.outValid && bus.outReady) popLog.push_back(bus.outData);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    bus.address = a;
    bus.writeData = d;
    bus.write = 1'b1;
    step();
    bus.write = 1'b0;
  endtask

  task automatic readAndCheck(input string name, input logic [1:0] a, input logic [31:0] expected);
    bus.address = a;
    bus.write = 1'b0;
    step();
    checkOutput(name, bus.readData, expected);
  endtask

  initial begin
    int r;
    bus.address = 2'd0;
    bus.write = 1'b0;
    bus.writeData = 32'd0;
    bus.outReady = 1'b0;

    step();
    checkEn = 1'b1;
    step();
    reset_n = 1'b1;
    readAndCheck("rstStatus", 2'd1, 32'h0000_0001);
    readAndCheck("rstEnable", 2'd2, 32'h0000_0000);
    checkOutput("rstValid", 32'(bus.outValid), 32'd0);

    applyStimulus(2'd2, 32'd1);
    bus.outReady = 1'b1;
    applyStimulus(2'd0, 32'hA5A5_0001);
    checkOutput("firstValid", 32'(bus.outValid), 32'd1);
    checkOutput("firstData", bus.outData, 32'hA5A5_0001);
    step();
    checkOutput("firstValidDrop", 32'(bus.outValid), 32'd0);

    bus.outReady = 1'b0;
    for (int i = 0; i < 16; i++) applyStimulus(2'd0, 32'(i));
    readAndCheck("fullStatus", 2'd1, 32'h0000_1002);
    applyStimulus(2'd0, 32'h0000_DEAD);
    readAndCheck("ovfStatus", 2'd1, 32'h0000_1006);
    bus.outReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("drain%0d", i), bus.outData, 32'(i));
      step();
    end
    bus.outReady = 1'b0;
    checkOutput("drainEmpty", 32'(bus.outValid), 32'd0);
    applyStimulus(2'd1, 32'd1);
    readAndCheck("ovfClear", 2'd1, 32'h0000_0001);

    for (int i = 0; i < 16; i++) applyStimulus(2'd0, 32'h100 + 32'(i));
    bus.outReady = 1'b1;
    applyStimulus(2'd0, 32'h0000_BEEF);
    bus.outReady = 1'b0;
    readAndCheck("pushPopFull", 2'd1, 32'h0000_0F04);
    checkOutput("pushPopHead", bus.outData, 32'h0000_0101);
    applyStimulus(2'd1, 32'd3);
    readAndCheck("flushClear", 2'd1, 32'h0000_0001);

    applyStimulus(2'd2, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(2'd0, 32'h200 + 32'(i));
    checkOutput("disabledValid", 32'(bus.outValid), 32'd0);
    readAndCheck("disabledHead", 2'd0, 32'h0000_0200);
    applyStimulus(2'd1, 32'd2);
    readAndCheck("flushStatus", 2'd1, 32'h0000_0001);
    readAndCheck("flushHead", 2'd0, 32'h0000_0000);

    applyStimulus(2'd2, 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(2'd0, 32'h300 + 32'(i));
    logPops = 1'b1;
    for (int c = 0; c < 9; c++) begin
      bus.outReady = (c % 2 == 0);
      step();
    end
    bus.outReady = 1'b0;
    logPops = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("resetValid", 32'(bus.outValid), 32'd0);
    step();
    reset_n = 1'b1;
    readAndCheck("resetStatus", 2'd1, 32'h0000_0001);
    readAndCheck("resetEnable", 2'd2, 32'h0000_0000);
    checkOutput("popCount", 32'(popLog.size()), 32'd5);
    for (int k = 0; k < popLog.size(); k++) begin
      checkOutput($sformatf("pop%0d", k), popLog[k], 32'h300 + 32'(k));
    end

    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      bus.write = 1'b0;
      bus.writeData = $urandom;
      bus.address = 2'($urandom_range(0, 3));
      if (r < 60) begin
        bus.write = 1'b1;
        bus.address = 2'd0;
      end else if (r < 64) begin
        bus.write = 1'b1;
        bus.address = 2'd1;
      end else if (r < 69) begin
        bus.write = 1'b1;
        bus.address = 2'd2;
        bus.writeData[0] = ($urandom_range(0, 3) != 0);
      end else if (r < 71) begin
        bus.write = 1'b1;
        bus.address = 2'd3;
      end
      if (c < 1500) bus.outReady = ($urandom_range(0, 3) == 0);
      else bus.outReady = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.write = 1'b0;
    bus.outReady = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/final_soc_cmd_out.md
# final_soc_cmd_out

Avalon-MM slave output mailbox: the write-direction counterpart of the SoC's read-only input ports. The Nios II writes 32-bit words (pixel data, commands) into an internal FIFO, and the FIFO drains to the recognition fabric over a valid/ready stream. Software-visible registers expose FIFO status, a sticky overflow flag, flush and output enable. The block sits on the Avalon bus beside the result input port and feeds the accelerator's data input.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..128
- WIDTH, 32, data width; fixed at 32 for the bus
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  Avalon word address
- write  in  1  Avalon write strobe; one-cycle pulse per access
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered, read latency 1
- out_data  out  WIDTH  stream data, head of FIFO
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from fabric

## Operation
- Register map, write side:
  - addr 0 pushes writedata into the FIFO.
  - addr 1: bit0=1 clears overflow; bit1=1 flushes the FIFO. Both may be set in one write.
  - addr 2: bit0 writes the enable bit.
  - addr 3 is ignored.
- Register map, read side (readdata updated every cycle from address; no read strobe):
  - addr 0: FIFO head, or 0 when empty.
  - addr 1: {16'b0, count[7:0], 5'b0, overflow, full, empty}.
  - addr 2: {31'b0, enable}.
  - addr 3: 0.
- FIFO is first-word-fall-through, with read/write pointers of log2(DEPTH) bits and count of 0..DEPTH.
  - empty = (count==0); full = (count==DEPTH).
- out_data = mem[rd_ptr], combinational from storage.
- out_valid = enable & ~empty.
- Pop occurs when out_valid & out_ready at a rising edge. rd_ptr increments mod DEPTH.
- Push occurs when write & address==0 & ~full, judged on the pre-edge count. wr_ptr increments mod DEPTH.
- Push while full: the word is dropped and overflow is set. This holds even when a pop happens the same cycle.
- Simultaneous push and pop (not full): both occur and count is unchanged.
- Overflow is sticky; only a write to addr 1 with bit0=1 clears it.
  - If overflow-clear and an overflow-causing push coincide: impossible, since there is a single write port.
- Flush sets rd_ptr=wr_ptr=0 and count=0, and wins over a same-cycle pop. Storage contents are not cleared.
- Disabling mid-stream: out_valid drops the next cycle and FIFO contents are retained. Re-enabling resumes at the same head.
- Reset clears:
  - count, pointers, overflow, enable to 0;
  - readdata to 0;
  - out_valid to 0.
  - out_data is undefined.
- Reset mid-stream discards all queued words.

## Timing
- Write-to-stream latency is 1 cycle. A push at edge N (FIFO empty, enable=1) gives out_valid=1 and out_data=word after edge N.
- A status read reflects state after the previous edge. readdata at edge N+1 shows the mux of the address presented in cycle N, using post-edge-N state.
- Pop throughput is 1 word/cycle while out_ready=1 and the FIFO is non-empty.
- Enable write at edge N makes out_valid change after edge N.
- out_valid is combinational from registers only. No combinational path exists from out_ready to out_valid.

## Test plan
- Reset, then read addr 1 and addr 2:
  - readdata 0x00000001 (empty), then 0x00000000;
  - out_valid=0.
- Enable=1, out_ready=1, write 0xA5A5_0001 to addr 0:
  - out_valid=1 for exactly one cycle after the write edge;
  - out_data=0xA5A50001.
- out_ready=0, push 16 words 0..15:
  - status 0x00001002 (count 16, full).
  - A 17th push 0xDEAD makes status 0x00001006.
  - Drain yields exactly 0..15 in order.
  - Write 0x1 to addr 1 clears overflow.
- FIFO full, out_ready=1, push in the same cycle as a pop:
  - the push is dropped, overflow=1, count=15.
- Push 5 words, enable=0:
  - out_valid stays 0 and addr 0 reads the first word.
  - Write 0x2 to addr 1: status 0x00000001, and addr 0 reads 0.
- Stream 8 words with out_ready toggling 1/0, and assert reset_n=0 mid-drain:
  - the sequence so far has no duplicates or skips;
  - after reset: out_valid=0, count=0, enable=0.
